// File: rtl/maxpool_stream.sv
// maxpool_stream
//   Streaming KxK max-pooling stage, stride equal to the window edge. Pixels
//   arrive in raster order, one per valid cycle. A single horizontal running
//   max plus one partial-max entry per output column replaces a full K-row
//   line buffer. One pooled pixel is emitted, registered, one cycle after the
//   pixel that completes each window.
//
//   Optional feature macro: MAXPOOL_RELU_EN -- when defined, the emitted value
//   is clamped at zero (fused ReLU).
//
// Parameters
//   DATA_WIDTH  pixel width, signed two's complement
//   IMG_WIDTH   input columns per row
//   IMG_HEIGHT  input rows per frame
//   POOL        window edge K (2..4)
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   i_data   input pixel
//   i_valid  i_data valid this cycle (gaps allowed, no backpressure)
//   o_data   pooled pixel
//   o_valid  one-cycle pulse per completed window
//   o_last   with o_valid on the final pooled pixel of a frame
module maxpool_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 224,
  parameter int IMG_HEIGHT = 224,
  parameter int POOL       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_last
);

  localparam int OUT_W = IMG_WIDTH / POOL;
  localparam int OUT_H = IMG_HEIGHT / POOL;
  // Column/row counters get one spare bit so the pooled-region bound fits.
  localparam int CW = $clog2(IMG_WIDTH + 1);
  localparam int RW = $clog2(IMG_HEIGHT + 1);
  localparam int KW = $clog2(POOL);
  localparam int WW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_END  = CW'(OUT_W * POOL);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_END  = RW'(OUT_H * POOL);
  localparam logic [RW-1:0] ROW_FIN  = RW'(OUT_H * POOL - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(POOL - 1);
  localparam logic [WW-1:0] W_LAST   = WW'(OUT_W - 1);

  typedef logic signed [DATA_WIDTH-1:0] pix_t;

  function automatic pix_t smax(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [KW-1:0] kx_q, kx_d;
  logic [KW-1:0] ky_q, ky_d;
  logic [WW-1:0] wcol_q, wcol_d;
  pix_t          hmax_q, hmax_d;
  pix_t          o_data_q, o_data_d;
  logic          o_valid_q, o_valid_d;
  logic          o_last_q, o_last_d;

  pix_t          pbuf_q [OUT_W];
  logic          pbuf_we;
  pix_t          pbuf_wdata;

  pix_t          pix;
  pix_t          hcur;
  pix_t          vcur;
  logic          in_region;

  always_comb begin
    pix       = pix_t'(i_data);
    hcur      = smax(hmax_q, pix);
    vcur      = smax(pbuf_q[wcol_q], hcur);
    in_region = (col_q < COL_END) && (row_q < ROW_END);

    col_d      = col_q;
    row_d      = row_q;
    kx_d       = kx_q;
    ky_d       = ky_q;
    wcol_d     = wcol_q;
    hmax_d     = hmax_q;
    pbuf_we    = 1'b0;
    pbuf_wdata = hcur;
    o_valid_d  = 1'b0;
    o_last_d   = 1'b0;
    o_data_d   = o_data_q;

    if (i_valid) begin
      if (in_region) begin
        if (kx_q == K_LAST) begin
          kx_d   = '0;
          wcol_d = (wcol_q == W_LAST) ? '0 : wcol_q + WW'(1);
          if (ky_q == '0) begin
            pbuf_we    = 1'b1;
            pbuf_wdata = hcur;
          end else if (ky_q == K_LAST) begin
            o_valid_d = 1'b1;
            o_last_d  = (wcol_q == W_LAST) && (row_q == ROW_FIN);
`ifdef MAXPOOL_RELU_EN
            o_data_d  = (vcur < 0) ? '0 : vcur;
`else
            o_data_d  = vcur;
`endif
          end else begin
            pbuf_we    = 1'b1;
            pbuf_wdata = vcur;
          end
        end else begin
          kx_d   = kx_q + KW'(1);
          hmax_d = (kx_q == '0) ? pix : hcur;
        end
      end

      // Row/frame wrap overrides the per-window advance above.
      if (col_q == COL_LAST) begin
        col_d  = '0;
        kx_d   = '0;
        wcol_d = '0;
        if (row_q == ROW_LAST) begin
          row_d = '0;
          ky_d  = '0;
        end else begin
          row_d = row_q + RW'(1);
          if (row_q < ROW_END) ky_d = (ky_q == K_LAST) ? '0 : ky_q + KW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q     <= '0;
      row_q     <= '0;
      kx_q      <= '0;
      ky_q      <= '0;
      wcol_q    <= '0;
      hmax_q    <= '0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      kx_q      <= kx_d;
      ky_q      <= ky_d;
      wcol_q    <= wcol_d;
      hmax_q    <= hmax_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
      o_last_q  <= o_last_d;
    end
  end

  // Contents need no reset: the first window-row of every frame overwrites.
  always_ff @(posedge clk) begin
    if (!rst && pbuf_we) pbuf_q[wcol_q] <= pbuf_wdata;
  end

  assign o_data  = o_data_q;
  assign o_valid = o_valid_q;
  assign o_last  = o_last_q;

endmodule

// File: doc/maxpool_stream.md
# maxpool_stream

Streaming, parametrised K×K max-pooling stage for the VGG16 feature-map datapath, with non-overlapping windows (stride = K). It accepts one pixel per valid cycle in raster order and keeps a per-window-column partial-max line buffer instead of a full K-row line buffer. It emits one pooled pixel per completed window, flagging the last output of each frame. It sits between a convolution/activation stage and the next convolution layer, one instance per channel.

## Interface
- DATA_WIDTH, 32, pixel width; signed two's complement
- IMG_WIDTH, 224, input columns per row
- IMG_HEIGHT, 224, input rows per frame
- POOL, 2, window edge K (legal 2..4); stride is fixed equal to POOL
- clk  input  1  clock; all logic rising-edge
- rst  input  1  synchronous, active-high reset
- i_data  input  DATA_WIDTH  input pixel
- i_valid  input  1  i_data valid this cycle; gaps allowed; no backpressure
- o_data  output  DATA_WIDTH  pooled pixel
- o_valid  output  1  o_data valid, one-cycle pulse per window
- o_last  output  1  high with o_valid on the final pooled pixel of a frame

## Operation
- Counters: col (0..IMG_WIDTH-1), row (0..IMG_HEIGHT-1), kx (0..POOL-1), ky (0..POOL-1), wcol (0..OUT_W-1). OUT_W = IMG_WIDTH/POOL and OUT_H = IMG_HEIGHT/POOL, both floor. All counters advance only on i_valid.
- Horizontal stage: register hmax. At kx==0 load i_data; otherwise hmax = max(hmax, i_data). Comparison is signed.
- Vertical stage: line buffer pbuf[OUT_W] of DATA_WIDTH entries. At kx==POOL-1, h = max(hmax, i_data).
  - If ky==0: pbuf[wcol] = h.
  - If 0<ky<POOL-1: pbuf[wcol] = max(pbuf[wcol], h).
  - If ky==POOL-1: emit max(pbuf[wcol], h). pbuf is not written.
- Edge discard: columns with col ≥ OUT_W·POOL and rows with row ≥ OUT_H·POOL are consumed but never update hmax/pbuf and never produce output.
- End of row: col wraps to 0, kx/wcol reset to 0, and ky advances (mod POOL) while inside the pooled region.
- End of frame (col==IMG_WIDTH-1, row==IMG_HEIGHT-1 accepted): all counters wrap to 0, and the next pixel starts a new frame with no idle cycle.
- o_last is asserted on the output produced for wcol==OUT_W-1 in window-row OUT_H-1.
- Equal values: either operand is acceptable, since the result is identical.

## Timing
- Reset values: o_data=0, o_valid=0, o_last=0, all counters 0. pbuf contents are don't-care, because ky==0 always overwrites.
- Latency: o_valid/o_data/o_last are registered and appear exactly 1 cycle after the accepted pixel that completes a window.
- Throughput: one input per cycle sustained. At most one output per POOL inputs.
- i_valid low: no state changes. o_valid deasserts the following cycle.
- rst during a frame: the partial frame is abandoned, and the first valid pixel after rst deasserts is treated as pixel (0,0). An output pending on the reset cycle is suppressed.
- A pbuf read-modify-write on a given wcol happens only once per POOL input cycles, so there is no read/write hazard with back-to-back inputs.

## Configuration
- MAXPOOL_RELU_EN defined: the emitted value is max(window_max, 0), i.e. fused ReLU, and negative results output 0. Latency is unchanged.
- Undefined: the raw signed window maximum is emitted.

## Test plan
- IMG 4×4, POOL=2, inputs 0..15 raster, continuous valid:
  - outputs 5, 7, 13, 15, each 1 cycle after inputs 5, 7, 13, 15
  - o_last only with 15
- Same frame, all values negated (0..-15), macro off:
  - outputs 0, -2, -8, -10
  - with MAXPOOL_RELU_EN: outputs 0, 0, 0, 0
- IMG 5×5, POOL=2, inputs 0..24:
  - outputs 6, 8, 16, 18
  - column 4 and row 4 produce nothing
  - o_last with 18
  - next frame starts cleanly at input 25
- IMG 6×6, POOL=3, inputs 0..35 with i_valid toggling 1,0 every cycle:
  - outputs 14, 17, 32, 35
  - each output 1 cycle after its completing valid input
- rst pulsed after 7 pixels of a 4×4 frame, then a full 0..15 frame:
  - no stale output
  - outputs 5, 7, 13, 15 exactly as in the first scenario
- Two back-to-back 4×4 frames with no gap:
  - eight outputs
  - o_last asserted exactly twice
